// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction-fetch sequencer. Owns the PC, drives the
// async-read instruction memory address, and streams {pc, instr} pairs to
// decode through a 2-entry buffer with a valid/ready handshake.
module imem_fetch_ctrl #(
   parameter int                ADDR_W   = 8,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
   parameter logic [ADDR_W-1:0] END_PC   = 8'h44
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_instr,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } entry_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [1:0]        count;
   entry_t            head;     // entry presented to decode
   entry_t            tail;     // second entry, valid only when count==2
   entry_t            new_ent;
   logic              pop, push, redir;
   logic [1:0]        count_nxt;

   // Handshake decode; a redirect suppresses this cycle's push.
   always_comb begin
      pop       = out_valid & out_ready;
      redir     = redirect_valid & ((state == FETCH) | (state == DRAIN));
      push      = (state == FETCH) & ((count < 2'd2) | pop) & ~redirect_valid;
      count_nxt = count + {1'b0, push} - {1'b0, pop};
      new_ent   = '{pc: pc, instr: imem_instr};
   end

   // FSM, PC and buffer state; redirect outranks every other update.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         pc    <= RESET_PC;
         count <= 2'd0;
         head  <= '0;
         tail  <= '0;
      end else if (redir) begin
         count <= 2'd0;
         pc    <= {redirect_pc[ADDR_W-1:2], 2'b00};
         state <= FETCH;
      end else begin
         if (pop && push) begin
            if (count == 2'd2) begin
               head <= tail;
               tail <= new_ent;
            end else begin
               head <= new_ent;
            end
         end else if (pop) begin
            head <= tail;
         end else if (push) begin
            if (count == 2'd0) head <= new_ent;
            else               tail <= new_ent;
         end
         count <= count_nxt;
         if (push) pc <= pc + ADDR_W'(4);

         case (state)
            IDLE, DONE: if (start) begin
               state <= FETCH;
               pc    <= RESET_PC;
            end
            FETCH: if (push && pc == END_PC) state <= DRAIN;
            DRAIN: if (count_nxt == 2'd0) state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs are direct decodes of registered state.
   always_comb begin
      imem_addr = pc;
      out_valid = (count != 2'd0);
      out_pc    = head.pc;
      out_instr = head.instr;
      busy      = (state == FETCH) | (state == DRAIN);
      done      = (state == DONE);
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed streams plus a per-cycle vector table
// covering backpressure, redirect, mid-run reset and restart, and a second
// instance exercising PC wrap-around.
module tb_imem_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, start, out_ready, redirect_valid;
   logic [7:0]  redirect_pc, imem_addr, out_pc;
   logic [31:0] imem_instr, out_instr;
   logic        out_valid, busy, done;

   logic        start_b, ready_b;
   logic [7:0]  addr_b, pc_b;
   logic [31:0] instr_b, oinstr_b;
   logic        valid_b, busy_b, done_b;

   logic [31:0] mem [64];
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   assign imem_instr = mem[imem_addr[7:2]];
   assign instr_b    = mem[addr_b[7:2]];

   imem_fetch_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .imem_addr(imem_addr),
      .imem_instr(imem_instr), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .busy(busy), .done(done));

   imem_fetch_ctrl #(.RESET_PC(8'hF8), .END_PC(8'h04)) dut_w (
      .clk(clk), .rst_n(rst_n), .start(start_b), .imem_addr(addr_b),
      .imem_instr(instr_b), .redirect_valid(1'b0), .redirect_pc(8'h00),
      .out_valid(valid_b), .out_ready(ready_b), .out_instr(oinstr_b),
      .out_pc(pc_b), .busy(busy_b), .done(done_b));

   typedef struct {
      logic       rst_n, start, ready, rv;
      logic [7:0] rpc;
      logic       valid;
      logic [7:0] pc, addr;
      logic       busy, done;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(logic r, logic s, logic rd, logic rv, logic [7:0] rpc,
                              logic vl, logic [7:0] pc, logic [7:0] ad, logic b, logic d);
      vec_t t;
      t.rst_n = r; t.start = s; t.ready = rd; t.rv = rv; t.rpc = rpc;
      t.valid = vl; t.pc = pc; t.addr = ad; t.busy = b; t.done = d;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full program stream from start; optional start pulse mid-stream must be ignored.
   task automatic run_stream(input bit mid_start);
      start = 1'b1; out_ready = 1'b1;
      step();
      start = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_valid", out_valid, 0);
      chk("start_addr", imem_addr, 8'h00);
      for (int k = 0; k < 18; k++) begin
         if (mid_start && k == 5) start = 1'b1;
         step();
         start = 1'b0;
         chk($sformatf("s_valid%0d", k), out_valid, 1);
         chk($sformatf("s_pc%0d", k), out_pc, 8'(4 * k));
         chk($sformatf("s_instr%0d", k), out_instr, mem[k]);
      end
      step();
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
      chk("end_valid", out_valid, 0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0013 + (i << 8);
      mem[0]  = 32'h0000_7033;
      mem[8]  = 32'h0020_8433;
      mem[17] = 32'h4d24_4893;

      rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 8'h00;
      start_b = 1'b0; ready_b = 1'b0;
      step(); step();
      chk("rst_valid", out_valid, 0);
      chk("rst_pc", out_pc, 0);
      chk("rst_instr", out_instr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr", imem_addr, 8'h00);
      rst_n = 1'b1;

      run_stream(1'b0);   // first run from IDLE
      run_stream(1'b1);   // restart from DONE, start mid-stream ignored

      //            rst s  rdy rv rpc    | vld pc     addr   busy done
      tbl.push_back(v(1, 0, 0, 1, 8'h40,   0, 8'h00, 8'h48, 0, 1)); // redirect ignored in DONE
      tbl.push_back(v(1, 1, 0, 0, 8'h00,   0, 8'h00, 8'h00, 1, 0));
      tbl.push_back(v(1, 0, 0, 0, 8'h00,   1, 8'h00, 8'h04, 1, 0));
      tbl.push_back(v(1, 0, 0, 0, 8'h00,   1, 8'h00, 8'h08, 1, 0)); // count 2
      tbl.push_back(v(1, 0, 0, 0, 8'h00,   1, 8'h00, 8'h08, 1, 0));
      tbl.push_back(v(1, 0, 0, 0, 8'h00,   1, 8'h00, 8'h08, 1, 0));
      tbl.push_back(v(1, 0, 0, 0, 8'h00,   1, 8'h00, 8'h08, 1, 0));
      tbl.push_back(v(1, 0, 1, 0, 8'h00,   1, 8'h04, 8'h0C, 1, 0)); // resume, no gap
      tbl.push_back(v(1, 0, 1, 0, 8'h00,   1, 8'h08, 8'h10, 1, 0));
      tbl.push_back(v(1, 0, 1, 1, 8'h23,   0, 8'h00, 8'h20, 1, 0)); // redirect flushes pop too
      tbl.push_back(v(1, 0, 0, 0, 8'h00,   1, 8'h20, 8'h24, 1, 0));
      tbl.push_back(v(1, 0, 0, 0, 8'h00,   1, 8'h20, 8'h28, 1, 0)); // count 2
      tbl.push_back(v(1, 1, 0, 0, 8'h00,   1, 8'h20, 8'h28, 1, 0)); // start ignored
      tbl.push_back(v(0, 0, 0, 0, 8'h00,   0, 8'h00, 8'h00, 0, 0)); // reset mid-run
      tbl.push_back(v(1, 1, 1, 0, 8'h00,   0, 8'h00, 8'h00, 1, 0));
      tbl.push_back(v(1, 0, 1, 0, 8'h00,   1, 8'h00, 8'h04, 1, 0));
      tbl.push_back(v(1, 0, 1, 0, 8'h00,   1, 8'h04, 8'h08, 1, 0));
      tbl.push_back(v(1, 0, 1, 0, 8'h00,   1, 8'h08, 8'h0C, 1, 0));

      foreach (tbl[i]) begin
         rst_n = tbl[i].rst_n; start = tbl[i].start; out_ready = tbl[i].ready;
         redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
         step();
         chk($sformatf("v%0d_valid", i), out_valid, tbl[i].valid);
         chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].addr);
         chk($sformatf("v%0d_busy", i), busy, tbl[i].busy);
         chk($sformatf("v%0d_done", i), done, tbl[i].done);
         if (tbl[i].valid) begin
            chk($sformatf("v%0d_pc", i), out_pc, tbl[i].pc);
            chk($sformatf("v%0d_instr", i), out_instr, mem[tbl[i].pc[7:2]]);
         end
      end
      rst_n = 1'b1; start = 1'b0; redirect_valid = 1'b0;

      // Wrap-around instance: F8, FC, 00, 04 then DONE.
      start_b = 1'b1; ready_b = 1'b1;
      step();
      start_b = 1'b0;
      chk("w_addr", addr_b, 8'hF8);
      chk("w_busy", busy_b, 1);
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("w_valid%0d", k), valid_b, 1);
         chk($sformatf("w_pc%0d", k), pc_b, 8'(8'hF8 + 4 * k));
         chk($sformatf("w_instr%0d", k), oinstr_b, mem[6'(62 + k)]);
      end
      step();
      chk("w_done", done_b, 1);
      chk("w_valid_end", valid_b, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
